mem_bus_if: RTL

MEM_BUS_IF -- requirements
Module: mem_bus_if

---
 rtl/mem_bus_if.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_if.sv
// Bridges the MEM pipeline stage to a single-outstanding bus master port.
// A request is captured from IDLE and driven, held stable, on the bus until
// it is acknowledged, flushed or times out. A load result is held for the
// MEM stage while the pipeline remains stalled after the acknowledge.
module mem_bus_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    output logic [3:0]  bus_sel_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i
);

    // The counter must be able to reach TIMEOUT_CYCLES itself, so it never wraps.
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [31:0]      rbuf_q,     rbuf_d;
    logic             bus_cyc_q,  bus_cyc_d;
    logic             bus_stb_q,  bus_stb_d;
    logic             bus_we_q,   bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_data_q, bus_data_d;
    logic [3:0]       bus_sel_q,  bus_sel_d;

    // Per-cycle events in BUSY; flush outranks both ack and timeout.
    logic busy, ack_ok, timeout;
    assign busy    = (state_q == S_BUSY);
    assign ack_ok  = busy && bus_ack_i && !flush_i;
    assign timeout = busy && !bus_ack_i && !flush_i && (cnt_q == CNT_MAX);

    // Next-state and bus-register update.
    always_comb begin
        // NOTE: every target gets a hold default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        rbuf_d     = rbuf_q;
        bus_cyc_d  = bus_cyc_q;
        bus_stb_d  = bus_stb_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        bus_sel_d  = bus_sel_q;
        case (state_q)
            S_IDLE: begin
                if (mem_ce_i && !flush_i) begin
                    bus_cyc_d  = 1'b1;
                    bus_stb_d  = 1'b1;
                    bus_we_d   = mem_we_i;
                    bus_addr_d = mem_addr_i;
                    bus_data_d = mem_data_i;
                    bus_sel_d  = mem_sel_i;
                    cnt_d      = '0;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_i || timeout) begin
                    bus_cyc_d  = 1'b0;
                    bus_stb_d  = 1'b0;
                    bus_we_d   = 1'b0;
                    bus_addr_d = '0;
                    bus_data_d = '0;
                    bus_sel_d  = '0;
                    state_d    = S_IDLE;
                end else if (ack_ok) begin
                    bus_cyc_d = 1'b0;
                    bus_stb_d = 1'b0;
                    bus_we_d  = 1'b0;
                    // Stores leave a zero buffer so WAIT_STALL returns 0 for them.
                    rbuf_d    = bus_we_q ? 32'h0 : bus_data_i;
                    state_d   = (stall_i != 6'd0) ? S_WAIT : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    rbuf_d  = '0;
                    state_d = S_IDLE;
                end else if (stall_i == 6'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rbuf_q     <= '0;
            bus_cyc_q  <= 1'b0;
            bus_stb_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            bus_sel_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rbuf_q     <= rbuf_d;
            bus_cyc_q  <= bus_cyc_d;
            bus_stb_q  <= bus_stb_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            bus_sel_q  <= bus_sel_d;
        end
    end

    // Combinational MEM-side outputs; reset silences them immediately.
    always_comb begin
        mem_data_o = 32'h0;
        stallreq_o = 1'b0;
        bus_err_o  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: stallreq_o = mem_ce_i && !flush_i;
                S_BUSY: begin
                    stallreq_o = !bus_ack_i && !flush_i && !timeout;
                    bus_err_o  = timeout;
                    if (ack_ok && !bus_we_q) mem_data_o = bus_data_i;
                end
                S_WAIT: mem_data_o = rbuf_q;
                default: ;
            endcase
        end
    end

    assign bus_cyc_o  = bus_cyc_q;
    assign bus_stb_o  = bus_stb_q;
    assign bus_we_o   = bus_we_q;
    assign bus_addr_o = bus_addr_q;
    assign bus_data_o = bus_data_q;
    assign bus_sel_o  = bus_sel_q;

endmodule
